// File: rtl/ctrl_pkg.sv
// Shared state codes for the inference phase sequencer and display block.
// Also holds the single-step resume encoding and its conversions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PE      = 3'd1,
        CONV3   = 3'd2,
        POOL2   = 3'd3,
        DISPLAY = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6,
        HOLD    = 3'd7
    } state_t;

    localparam logic [2:0] DISP_DONE_CODE = 3'd4;

    // Phase to resume after a single-step HOLD.
    typedef enum logic [1:0] {
        NX_CONV3   = 2'd0,
        NX_POOL2   = 2'd1,
        NX_DISPLAY = 2'd2
    } step_nxt_t;

    function automatic step_nxt_t step_code(input state_t s);
        case (s)
            CONV3:   return NX_CONV3;
            POOL2:   return NX_POOL2;
            default: return NX_DISPLAY;
        endcase
    endfunction

    function automatic state_t step_state(input step_nxt_t c);
        case (c)
            NX_CONV3: return CONV3;
            NX_POOL2: return POOL2;
            default:  return DISPLAY;
        endcase
    endfunction

endpackage

// File: rtl/compute_seq_ctrl_watchdog.sv
// phase_watchdog: per-phase cycle counter with clear, enable and expire.
// Ports: clk, reset (async high), clr, en in; expire out (combinational).
module phase_watchdog #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt;

    assign expire = en && (cnt == LIMIT);

    // Saturates at LIMIT; the FSM always leaves the phase on expire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/compute_seq_ctrl.sv
// compute_seq_ctrl: sequences PE -> CONV3 -> POOL2 -> DISPLAY with a
// per-phase watchdog. Ports: clk, reset, start_i, *_done_i, disp_state_i
// in; run_*_o, state_o, busy_o, done_o, error_o out. Optional macro
// CTRL_SINGLE_STEP_EN adds step_i and a HOLD state between phases.
module compute_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int         TIMEOUT_W      = 8,
    parameter int         TIMEOUT_CYC    = 200,
    parameter logic [2:0] DISP_DONE_CODE = ctrl_pkg::DISP_DONE_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       pe_done_i,
    input  logic       conv3_done_i,
    input  logic       pool2_done_i,
    input  logic [2:0] disp_state_i,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    output logic       run_pe_o,
    output logic       run_conv3_o,
    output logic       run_pool2_o,
    output logic       run_display_o,
    output logic [2:0] state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    state_t state, state_nxt, phase_nxt;
    logic   phase_done;
    logic   wd_en, wd_clr, wd_exp;

`ifdef CTRL_SINGLE_STEP_EN
    step_nxt_t step_q, step_d;
`endif

    phase_watchdog #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wd (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef CTRL_SINGLE_STEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            step_q <= NX_CONV3;
        else
            step_q <= step_d;
    end
`endif

    always_comb begin
        state_nxt  = state;
        phase_nxt  = state;
        phase_done = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step_d     = step_q;
`endif
        unique case (state)
            IDLE:  if (start_i) state_nxt = PE;
            PE: begin
                phase_done = pe_done_i;
                phase_nxt  = CONV3;
            end
            CONV3: begin
                phase_done = conv3_done_i;
                phase_nxt  = POOL2;
            end
            POOL2: begin
                phase_done = pool2_done_i;
                phase_nxt  = DISPLAY;
            end
            DISPLAY: begin
                phase_done = (disp_state_i == DISP_DONE_CODE);
                phase_nxt  = DONE;
            end
            DONE:  state_nxt = IDLE;
            ERROR: if (start_i) state_nxt = PE;
            HOLD: begin
`ifdef CTRL_SINGLE_STEP_EN
                if (step_i) state_nxt = step_state(step_q);
`else
                state_nxt = IDLE;
`endif
            end
        endcase

        // A done in the expiry cycle takes priority over the timeout.
        if (phase_done) begin
`ifdef CTRL_SINGLE_STEP_EN
            if (state != DISPLAY) begin
                state_nxt = HOLD;
                step_d    = step_code(phase_nxt);
            end else begin
                state_nxt = phase_nxt;
            end
`else
            state_nxt = phase_nxt;
`endif
        end else if (wd_exp) begin
            state_nxt = ERROR;
        end
    end

    assign wd_en  = (state == PE) || (state == CONV3) ||
                    (state == POOL2) || (state == DISPLAY);
    assign wd_clr = (state_nxt != state);

    assign run_pe_o      = (state == PE);
    assign run_conv3_o   = (state == CONV3);
    assign run_pool2_o   = (state == POOL2);
    assign run_display_o = (state == DISPLAY);
    assign state_o       = state;
    assign busy_o        = !((state == IDLE) || (state == DONE) ||
                             (state == ERROR));
    assign done_o        = (state == DONE);
    // ERROR is only left by a restart, which makes the flag sticky.
    assign error_o       = (state == ERROR);

endmodule

// File: tb/tb_compute_seq_ctrl.sv
// Directed bench for compute_seq_ctrl: nominal run, spurious inputs,
// coincident done/timeout, timeout, reset mid-run, optional single-step.
module tb_compute_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i, pe_done_i, conv3_done_i, pool2_done_i, step_i;
    logic [2:0] disp_state_i;
    logic       run_pe_o, run_conv3_o, run_pool2_o, run_display_o;
    logic [2:0] state_o;
    logic       busy_o, done_o, error_o;

    int n_chk  = 0;
    int n_pass = 0;
    int ovl    = 0;
    int ndone  = 0;

    compute_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .pe_done_i    (pe_done_i),
        .conv3_done_i (conv3_done_i),
        .pool2_done_i (pool2_done_i),
        .disp_state_i (disp_state_i),
`ifdef CTRL_SINGLE_STEP_EN
        .step_i       (step_i),
`endif
        .run_pe_o     (run_pe_o),
        .run_conv3_o  (run_conv3_o),
        .run_pool2_o  (run_pool2_o),
        .run_display_o(run_display_o),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if ((32'(run_pe_o) + 32'(run_conv3_o) + 32'(run_pool2_o) +
                 32'(run_display_o)) > 1)
                ovl++;
            if (done_o) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] exp_run(input int st);
        case (st)
            1:       return 4'b1000;
            2:       return 4'b0100;
            3:       return 4'b0010;
            4:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk_ph(input string tag, input int st);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_run"},
            32'({run_pe_o, run_conv3_o, run_pool2_o, run_display_o}),
            32'(exp_run(st)));
    endtask

    // Called one negedge after a phase-done was sampled.
    task automatic step_to(input string tag, input int st);
`ifdef CTRL_SINGLE_STEP_EN
        chk({tag, "_hold"}, 32'(state_o), 32'd7);
        chk({tag, "_hold_busy"}, 32'(busy_o), 32'd1);
        step_i = 1'b1;
        tick(1);
        step_i = 1'b0;
`endif
        chk_ph(tag, st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        start_i = 0; pe_done_i = 0; conv3_done_i = 0;
        pool2_done_i = 0; step_i = 0; disp_state_i = 3'd0;
        tick(2);
        chk_ph("rst", 0);
        chk("rst_outs", 32'({busy_o, done_o, error_o}), 32'd0);
        reset = 1'b0;
        tick(1);
        chk_ph("idle", 0);

        // Nominal run
        start_i = 1; tick(1); start_i = 0;
        chk_ph("nom_pe", 1);
        chk("nom_busy", 32'(busy_o), 32'd1);
        tick(4); pe_done_i = 1; tick(1); pe_done_i = 0;
        step_to("nom_conv3", 2);
        tick(4); conv3_done_i = 1; tick(1); conv3_done_i = 0;
        step_to("nom_pool2", 3);
        tick(4); pool2_done_i = 1; tick(1); pool2_done_i = 0;
        step_to("nom_disp", 4);
        tick(4); disp_state_i = 3'd3; tick(7);
        chk_ph("nom_disp_wait", 4);
        disp_state_i = 3'd4; tick(1); disp_state_i = 3'd0;
        chk_ph("nom_done", 5);
        chk("nom_done_o", 32'(done_o), 32'd1);
        chk("nom_done_busy", 32'(busy_o), 32'd0);
        tick(1);
        chk_ph("nom_idle", 0);
        chk("nom_done_clr", 32'(done_o), 32'd0);
        chk("nom_ndone", 32'(ndone), 32'd1);

        // Spurious inputs
        pool2_done_i = 1; tick(1); pool2_done_i = 0;
        chk_ph("spur_idle", 0);
        start_i = 1; tick(1); start_i = 0;
        chk_ph("spur_pe", 1);
        pool2_done_i = 1; tick(1); pool2_done_i = 0;
        chk_ph("spur_pe_pool", 1);
        conv3_done_i = 1; tick(1); conv3_done_i = 0;
        chk_ph("spur_pe_conv", 1);
        pe_done_i = 1; tick(1); pe_done_i = 0;
        step_to("spur_conv3", 2);
        start_i = 1; tick(1); start_i = 0;
        chk_ph("spur_start", 2);
        conv3_done_i = 1; tick(1); conv3_done_i = 0;
        step_to("spur_pool2", 3);
        pool2_done_i = 1; tick(1); pool2_done_i = 0;
        step_to("spur_disp", 4);

        // start_i held through DONE: DONE -> IDLE -> PE
        disp_state_i = 3'd4; start_i = 1; tick(1); disp_state_i = 3'd0;
        chk_ph("hold_done", 5);
        tick(1);
        chk_ph("hold_idle", 0);
        tick(1); start_i = 0;
        chk_ph("hold_pe", 1);

        // Done on the exact timeout cycle wins
        tick(199); pe_done_i = 1; tick(1); pe_done_i = 0;
        chk("coinc_err", 32'(error_o), 32'd0);
        step_to("coinc", 2);

        // CONV3 timeout
        tick(199);
        chk_ph("to_edge", 2);
        chk("to_edge_err", 32'(error_o), 32'd0);
        tick(1);
        chk_ph("to_err", 6);
        chk("to_err_o", 32'(error_o), 32'd1);
        chk("to_busy", 32'(busy_o), 32'd0);
        tick(5); conv3_done_i = 1; tick(1); conv3_done_i = 0;
        chk_ph("to_held", 6);
        chk("to_held_o", 32'(error_o), 32'd1);
        start_i = 1; tick(1); start_i = 0;
        chk_ph("to_restart", 1);
        chk("to_restart_err", 32'(error_o), 32'd0);

        // Reset mid-run in POOL2
        pe_done_i = 1; tick(1); pe_done_i = 0;
        step_to("rm_conv3", 2);
        conv3_done_i = 1; tick(1); conv3_done_i = 0;
        step_to("rm_pool2", 3);
        #2 reset = 1'b1;
        #1;
        chk_ph("rm_async", 0);
        chk("rm_outs", 32'({busy_o, done_o, error_o}), 32'd0);
        tick(1); reset = 1'b0;
        tick(3);
        chk_ph("rm_after", 0);

`ifdef CTRL_SINGLE_STEP_EN
        start_i = 1; tick(1); start_i = 0;
        pe_done_i = 1; tick(1); pe_done_i = 0;
        chk_ph("ss_hold", 7);
        tick(250);
        chk_ph("ss_hold_long", 7);
        chk("ss_no_err", 32'(error_o), 32'd0);
        chk("ss_busy", 32'(busy_o), 32'd1);
        step_i = 1; tick(1); step_i = 0;
        chk_ph("ss_conv3", 2);
`endif

        chk("no_overlap", 32'(ovl), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/compute_seq_ctrl.md
Name: compute_seq_ctrl

Overview:
- Top-level phase sequencer for the inference datapath.
- Runs four phases in order:
  - PE matrix unit
  - 3x3 convolution unit
  - 2x2 pooling unit
  - result display block, driven through its run_display input and observed through its 3-bit display-state output
- Enforces one active phase at a time, detects hung units with a per-phase watchdog, and reports busy/done/error to the host.

Parameters:
- TIMEOUT_W, 8, width of the per-phase watchdog counter.
- TIMEOUT_CYC, 200, cycles allowed per phase before error; must be < 2^TIMEOUT_W.
- DISP_DONE_CODE, 4, display-state value meaning "display finished".

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  host start request, level-sampled.
- pe_done_i  input  1  PE unit finished; 1-cycle pulse or held level.
- conv3_done_i  input  1  3x3 unit finished.
- pool2_done_i  input  1  2x2 unit finished.
- disp_state_i  input  3  state code reported by the display block.
- run_pe_o  output  1  enable for the PE unit.
- run_conv3_o  output  1  enable for the 3x3 unit.
- run_pool2_o  output  1  enable for the 2x2 unit.
- run_display_o  output  1  enable for the display block.
- state_o  output  3  current FSM state code.
- busy_o  output  1  high whenever state is not IDLE, DONE or ERROR.
- done_o  output  1  one-cycle pulse when a full sequence completes.
- error_o  output  1  sticky watchdog error flag.

Behaviour:
- Reset is asynchronous, active-high, on clk. All outputs reset to 0: state_o = IDLE(0), timer = 0.
- State codes: IDLE=0, PE=1, CONV3=2, POOL2=3, DISPLAY=4, DONE=5, ERROR=6, HOLD=7. HOLD is used only with the optional feature.
- All outputs are registered and decoded from the state register:
  - run_pe_o = (state==PE); run_conv3_o, run_pool2_o and run_display_o are decoded the same way.
  - At most one run_* output is high in any cycle.
- Transitions:
  - IDLE: start_i=1 -> PE next cycle; clear error_o and timer.
  - PE: pe_done_i=1 -> CONV3.
  - CONV3: conv3_done_i=1 -> POOL2.
  - POOL2: pool2_done_i=1 -> DISPLAY.
  - DISPLAY: disp_state_i==DISP_DONE_CODE -> DONE.
  - DONE: done_o=1 for exactly this cycle, then IDLE unconditionally.
  - ERROR: stays until start_i=1, then -> PE with error_o cleared. A restart from ERROR therefore needs no intermediate IDLE.
- Latency: a done input sampled high at edge N causes the next run_* output to rise at edge N+1. The previous run_* output falls at the same edge, so there is no overlap and no gap.
- Watchdog:
  - Timer clears on every state change.
  - Timer increments each cycle in PE, CONV3, POOL2 and DISPLAY.
  - If timer reaches TIMEOUT_CYC-1 with no done condition -> ERROR; error_o=1 from the next cycle.
  - If a done condition and the timeout occur in the same cycle, done wins and the FSM advances.
- Ignored or held inputs:
  - Done inputs not matching the current state are ignored, including stale pulses arriving in IDLE.
  - start_i while busy is ignored; start_i is not queued.
  - start_i held high through DONE starts a new run one cycle after DONE (DONE -> IDLE -> PE).
- Reset during any phase returns to IDLE immediately. All run_* outputs drop asynchronously.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input port step_i (1 bit).
  - After the done of PE, CONV3 or POOL2, the FSM enters HOLD instead of the next phase; the next phase is recorded in a 2-bit register.
  - HOLD has no run_* output asserted, busy_o=1 and no watchdog.
  - step_i=1 -> recorded next phase.
- When undefined: no step_i port; HOLD is unreachable.

Decomposition:
- Shared package ctrl_pkg holds the 3-bit state code constants IDLE..HOLD and DISP_DONE_CODE. The display block uses the same codes.
- One sub-module is natural: phase_watchdog, the clear/enable/expire counter parameterized by TIMEOUT_W and TIMEOUT_CYC.
- The FSM and output decode stay in compute_seq_ctrl.

Test Plan:
- Nominal run: start_i pulse; each done input returned 5 cycles after its run_* rises; disp_state_i=4 after 12 cycles -> state_o 1,2,3,4,5,0 in order; done_o is a single 1-cycle pulse; run_* outputs never overlap.
- Timeout: start; never assert conv3_done_i -> ERROR at 200 cycles after CONV3 entry; error_o=1 held; then start_i -> PE with error_o=0.
- Spurious inputs: pool2_done_i pulsed in IDLE and during PE; start_i pulsed during CONV3 -> no state change, no extra run.
- Reset mid-run: assert reset in POOL2 -> all outputs 0 asynchronously; after release, state_o=0 until start_i.
- Coincident events: pe_done_i asserted on the exact timeout cycle -> advance to CONV3, error_o stays 0.
- CTRL_SINGLE_STEP_EN build: pe_done_i -> state_o=7, no run_* high for 50 cycles (no error); step_i -> CONV3.
